// File: rtl/gp_register_bank_pkg.sv
// Shared types for the general-purpose register bank: write actions and
// the priority decode of the active-low write-port controls.
package gp_regbank_pkg;

    typedef enum logic [1:0] {
        WR_NONE = 2'd0,
        WR_LOAD = 2'd1,
        WR_INC  = 2'd2,
        WR_DEC  = 2'd3
    } wr_act_e;

    // Load beats inc/dec; inc and dec together cancel out to no action.
    function automatic wr_act_e wr_decode(input logic loadn,
                                          input logic incn,
                                          input logic decn);
        wr_act_e act;
        act = WR_NONE;
        if (!loadn)
            act = WR_LOAD;
        else if (!incn && decn)
            act = WR_INC;
        else if (!decn && incn)
            act = WR_DEC;
        return act;
    endfunction

endpackage

// File: rtl/gp_reg_cell.sv
// One WIDTH-bit register of the bank: applies the decoded write action and
// flags when that action is an increment/decrement that wraps around.
module gp_reg_cell
    import gp_regbank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  wr_act_e          act,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             wraps
);

    logic [WIDTH-1:0] next_q;

    // Next value and wrap detect for the requested action.
    always_comb begin
        next_q = q;
        wraps  = 1'b0;
        case (act)
            WR_LOAD: next_q = din;
            WR_INC: begin
                next_q = q + WIDTH'(1);
                wraps  = &q;
            end
            WR_DEC: begin
                next_q = q - WIDTH'(1);
                wraps  = ~|q;
            end
            default: next_q = q;
        endcase
    end

    // Register storage, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else
            q <= next_q;
    end

endmodule

// File: rtl/gp_register_bank.sv
// Register bank behind a shared tristate bus, with per-register inc/dec,
// a zero flag on the write target, a wrap pulse and two ALU operand latches.
module gp_register_bank
    import gp_regbank_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int COUNT = 4,
    localparam int SEL_W = $clog2(COUNT)
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             outn,
    input  logic [SEL_W-1:0] osel,
    input  logic             loadn,
    input  logic             incn,
    input  logic             decn,
    input  logic [SEL_W-1:0] wsel,
    input  logic             loutn,
    input  logic [SEL_W-1:0] lsel,
    input  logic             routn,
    input  logic [SEL_W-1:0] rsel,
    output logic [WIDTH-1:0] alu_l,
    output logic [WIDTH-1:0] alu_r,
    output logic             wz,
    output logic             wrap
);

    logic [COUNT-1:0][WIDTH-1:0] regs;
    logic [COUNT-1:0]            cell_wraps;
    wr_act_e                     act;

    assign act = wr_decode(loadn, incn, decn);

    // Only the cell addressed by wsel sees the action; the rest hold.
    for (genvar i = 0; i < COUNT; i++) begin : g_cell
        gp_reg_cell #(.WIDTH(WIDTH)) u_cell (
            .clk   (clk),
            .reset (reset),
            .act   ((wsel == SEL_W'(i)) ? act : WR_NONE),
            .din   (bus),
            .q     (regs[i]),
            .wraps (cell_wraps[i])
        );
    end

    // Self-transfer is safe: the cell samples bus at the edge and the bus
    // value is just its own current contents, so nothing loops.
    assign bus = (!outn && !reset) ? regs[osel] : {WIDTH{1'bz}};

    assign wz = (regs[wsel] == '0);

    // Wrap pulse: set only on the edge a wrapping inc/dec is applied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wrap <= 1'b0;
        else
            wrap <= |cell_wraps;
    end

    // Operand latches capture pre-edge register contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_l <= '0;
            alu_r <= '0;
        end else begin
            if (!loutn)
                alu_l <= regs[lsel];
            if (!routn)
                alu_r <= regs[rsel];
        end
    end

endmodule

// File: tb/tb_gp_register_bank.sv
// Directed bench for gp_register_bank: default 8x4 instance plus a 16x8
// instance sharing clock and reset.
module tb_gp_register_bank;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    // 8-bit, 4-register instance
    wire  [7:0] bus8;
    logic [7:0] drv8 = '0;
    logic       den8 = 1'b0;
    logic       oe8 = 1'b1, ld8 = 1'b1, inc8 = 1'b1, dec8 = 1'b1;
    logic       lo8 = 1'b1, ro8 = 1'b1;
    logic [1:0] os8 = '0, ws8 = '0, ls8 = '0, rs8 = '0;
    logic [7:0] alu_l8, alu_r8;
    logic       wz8, wrap8;

    assign bus8 = den8 ? drv8 : 8'bz;

    gp_register_bank u_dut8 (
        .clk(clk), .reset(reset), .bus(bus8), .outn(oe8), .osel(os8),
        .loadn(ld8), .incn(inc8), .decn(dec8), .wsel(ws8),
        .loutn(lo8), .lsel(ls8), .routn(ro8), .rsel(rs8),
        .alu_l(alu_l8), .alu_r(alu_r8), .wz(wz8), .wrap(wrap8)
    );

    // 16-bit, 8-register instance
    wire  [15:0] bus16;
    logic [15:0] drv16 = '0;
    logic        den16 = 1'b0;
    logic        oe16 = 1'b1, ld16 = 1'b1, inc16 = 1'b1, dec16 = 1'b1;
    logic        lo16 = 1'b1, ro16 = 1'b1;
    logic [2:0]  os16 = '0, ws16 = '0, ls16 = '0, rs16 = '0;
    logic [15:0] alu_l16, alu_r16;
    logic        wz16, wrap16;

    assign bus16 = den16 ? drv16 : 16'bz;

    gp_register_bank #(.WIDTH(16), .COUNT(8)) u_dut16 (
        .clk(clk), .reset(reset), .bus(bus16), .outn(oe16), .osel(os16),
        .loadn(ld16), .incn(inc16), .decn(dec16), .wsel(ws16),
        .loutn(lo16), .lsel(ls16), .routn(ro16), .rsel(rs16),
        .alu_l(alu_l16), .alu_r(alu_r16), .wz(wz16), .wrap(wrap16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load8(input logic [1:0] s, input logic [7:0] v);
        den8 = 1'b1; drv8 = v; oe8 = 1'b1; ld8 = 1'b0; ws8 = s;
        tick();
        ld8 = 1'b1; den8 = 1'b0;
    endtask

    task automatic rd8(input logic [1:0] s, output logic [7:0] v);
        oe8 = 1'b0; os8 = s;
        #1;
        v = bus8;
        oe8 = 1'b1;
    endtask

    task automatic load16(input logic [2:0] s, input logic [15:0] v);
        den16 = 1'b1; drv16 = v; oe16 = 1'b1; ld16 = 1'b0; ws16 = s;
        tick();
        ld16 = 1'b1; den16 = 1'b0;
    endtask

    task automatic rd16(input logic [2:0] s, output logic [15:0] v);
        oe16 = 1'b0; os16 = s;
        #1;
        v = bus16;
        oe16 = 1'b1;
    endtask

    initial begin
        logic [7:0]  v8;
        logic [15:0] v16;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // preload and capture so reset has something to clear
        load8(0, 8'h11); load8(1, 8'h22); load8(2, 8'h33); load8(3, 8'h44);
        rd8(1, v8); chk("pre_rb", v8, 8'h22);
        lo8 = 1'b0; ls8 = 2'd3; ro8 = 1'b0; rs8 = 2'd2;
        tick();
        lo8 = 1'b1; ro8 = 1'b1;
        chk("pre_alu_l", alu_l8, 8'h44);
        chk("pre_alu_r", alu_r8, 8'h33);
        load8(3, 8'hFF);
        ws8 = 2'd3; inc8 = 1'b0;
        tick();
        inc8 = 1'b1;
        chk("pre_wrap", wrap8, 1'b1);

        // mid-cycle reset with outn low: DUT must not drive the bus
        #2 reset = 1'b1; oe8 = 1'b0; den8 = 1'b1; drv8 = 8'h5A;
        #1;
        chk("rst_bus", bus8, 8'h5A);
        chk("rst_alu_l", alu_l8, 8'h00);
        chk("rst_alu_r", alu_r8, 8'h00);
        chk("rst_wrap", wrap8, 1'b0);
        tick();
        reset = 1'b0; den8 = 1'b0; oe8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd8(2'(i), v8); chk($sformatf("rst_r%0d", i), v8, 8'h00);
        end
        tick();

        // load / readback
        load8(2, 8'h3A);
        rd8(2, v8); chk("ld_r2", v8, 8'h3A);
        rd8(1, v8); chk("ld_r1", v8, 8'h00);

        // increment and decrement wrap
        load8(1, 8'hFF);
        ws8 = 2'd1; inc8 = 1'b0;
        tick();
        inc8 = 1'b1;
        rd8(1, v8); chk("inc_r1", v8, 8'h00);
        chk("inc_wz", wz8, 1'b1);
        chk("inc_wrap", wrap8, 1'b1);
        tick();
        chk("wrap_clr", wrap8, 1'b0);
        dec8 = 1'b0;
        tick();
        dec8 = 1'b1;
        rd8(1, v8); chk("dec_r1", v8, 8'hFF);
        chk("dec_wrap", wrap8, 1'b1);
        chk("dec_wz", wz8, 1'b0);

        // priority: load wins, inc+dec is a no-op
        load8(0, 8'h10);
        den8 = 1'b1; drv8 = 8'h55; ld8 = 1'b0; inc8 = 1'b0; ws8 = 2'd0;
        tick();
        ld8 = 1'b1; inc8 = 1'b1; den8 = 1'b0;
        rd8(0, v8); chk("pri_ld", v8, 8'h55);
        chk("pri_ld_wrap", wrap8, 1'b0);
        inc8 = 1'b0; dec8 = 1'b0;
        tick();
        inc8 = 1'b1; dec8 = 1'b1;
        rd8(0, v8); chk("pri_incdec", v8, 8'h55);
        chk("pri_incdec_wrap", wrap8, 1'b0);
        // load of r1 (0xFF) with inc asserted: load wins, no wrap
        den8 = 1'b1; drv8 = 8'hFF; ld8 = 1'b0; inc8 = 1'b0; ws8 = 2'd1;
        tick();
        ld8 = 1'b1; inc8 = 1'b1; den8 = 1'b0;
        rd8(1, v8); chk("pri_ld_ff", v8, 8'hFF);
        chk("ld_no_wrap", wrap8, 1'b0);

        // latches take the pre-edge value of a register written on that edge
        load8(3, 8'h07);
        den8 = 1'b1; drv8 = 8'h99; ld8 = 1'b0; ws8 = 2'd3;
        lo8 = 1'b0; ro8 = 1'b0; ls8 = 2'd3; rs8 = 2'd3;
        tick();
        ld8 = 1'b1; den8 = 1'b0; lo8 = 1'b1; ro8 = 1'b1;
        chk("lat_l_old", alu_l8, 8'h07);
        chk("lat_r_old", alu_r8, 8'h07);
        rd8(3, v8); chk("lat_r3", v8, 8'h99);
        lo8 = 1'b0; ro8 = 1'b0;
        tick();
        lo8 = 1'b1; ro8 = 1'b1;
        chk("lat_l_new", alu_l8, 8'h99);
        chk("lat_r_new", alu_r8, 8'h99);

        // bus move r0 -> r1, then self-transfer of r1
        load8(0, 8'h42);
        oe8 = 1'b0; os8 = 2'd0; ld8 = 1'b0; ws8 = 2'd1;
        tick();
        ld8 = 1'b1; oe8 = 1'b1;
        rd8(1, v8); chk("move_r1", v8, 8'h42);
        oe8 = 1'b0; os8 = 2'd1; ld8 = 1'b0; ws8 = 2'd1;
        tick();
        ld8 = 1'b1; oe8 = 1'b1;
        rd8(1, v8); chk("self_r1", v8, 8'h42);
        chk("lat_hold", alu_l8, 8'h99);

        // 16-bit, 8-register instance: load and wrap
        load16(5, 16'h3A5C);
        rd16(5, v16); chk("w_ld_r5", v16, 16'h3A5C);
        rd16(4, v16); chk("w_ld_r4", v16, 16'h0000);
        load16(7, 16'hFFFF);
        ws16 = 3'd7; inc16 = 1'b0;
        tick();
        inc16 = 1'b1;
        rd16(7, v16); chk("w_inc_r7", v16, 16'h0000);
        chk("w_inc_wz", wz16, 1'b1);
        chk("w_inc_wrap", wrap16, 1'b1);
        tick();
        chk("w_wrap_clr", wrap16, 1'b0);
        dec16 = 1'b0;
        tick();
        dec16 = 1'b1;
        rd16(7, v16); chk("w_dec_r7", v16, 16'hFFFF);
        chk("w_dec_wrap", wrap16, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gp_register_bank.md
# gp_register_bank

Parametrised general-purpose register bank for the 8-bit CPU emulator, successor to the single general-purpose register. Holds `COUNT` registers of `WIDTH` bits behind one shared tristate data bus, adds per-register increment/decrement for pointer and counter use, and provides two independently selectable ALU operand latches. Sits between the system bus and the ALU inputs.

## Interface
Parameters:
- `WIDTH`, 8: register and bus width in bits (≥ 2).
- `COUNT`, 4: number of registers (power of two, ≥ 2); `SEL_W = $clog2(COUNT)` is derived, not overridable.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `bus`  inout  `WIDTH`  shared data bus; driven only while `outn` = 0.
- `outn`  in  1  active-low bus output enable.
- `osel`  in  `SEL_W`  register driven onto `bus`.
- `loadn`  in  1  active-low load of `bus` into `reg[wsel]`.
- `incn`  in  1  active-low increment of `reg[wsel]`.
- `decn`  in  1  active-low decrement of `reg[wsel]`.
- `wsel`  in  `SEL_W`  target register for load/inc/dec.
- `loutn`  in  1  active-low capture into ALU left latch.
- `lsel`  in  `SEL_W`  source register for `alu_l`.
- `routn`  in  1  active-low capture into ALU right latch.
- `rsel`  in  `SEL_W`  source register for `alu_r`.
- `alu_l`  out  `WIDTH`  ALU left operand latch.
- `alu_r`  out  `WIDTH`  ALU right operand latch.
- `wz`  out  1  combinational: `reg[wsel]` == 0.
- `wrap`  out  1  registered one-cycle pulse: last inc/dec wrapped.

## Operation
- Reset (async, while `reset` = 1): all registers, `alu_l`, `alu_r`, `wrap` = 0; `bus` = Z regardless of `outn`.
- Bus drive: `bus` = `reg[osel]` when `outn` = 0 and `reset` = 0, else Z. Combinational.
- Write-port priority per edge (one action on `reg[wsel]`):
  - `loadn` = 0: `reg[wsel]` ← `bus`; `incn`/`decn` ignored.
  - else `incn` = 0, `decn` = 1: `reg[wsel]` ← `reg[wsel]` + 1 mod 2^`WIDTH`.
  - else `decn` = 0, `incn` = 1: `reg[wsel]` ← `reg[wsel]` − 1 mod 2^`WIDTH`.
  - `incn` = `decn` = 0 (no load): no change, `wrap` = 0.
- `wrap` ← 1 on the edge where increment from all-ones or decrement from 0 is performed; otherwise ← 0 on every edge. Loads never set `wrap`.
- Operand latches: `loutn` = 0 at edge → `alu_l` ← `reg[lsel]`; `routn` = 0 → `alu_r` ← `reg[rsel]`; otherwise hold. Both may capture the same register on the same edge.
- Latches always capture the pre-edge register value, including when the same register is written on that edge.
- Self-transfer (`outn` = 0, `loadn` = 0, `osel` = `wsel`): register reloads its own value; no change, no loop.
- Bus-to-bus move (`osel` ≠ `wsel`): completes in one edge.
- Contention from an external driver while `outn` = 0 is not detected; bus arbitration is the controller's responsibility.

## Timing
- Load/inc/dec: result visible on `bus`, `wz`, latch sources one edge after the control is sampled low.
- Latch capture: `alu_l`/`alu_r` valid immediately after the capturing edge; 1-cycle latency from control.
- `wrap`: high exactly the cycle following the wrapping edge.
- `reset` asserted mid-cycle clears state immediately; first action after deassertion is taken at the next rising edge with `reset` = 0.
- Select inputs and active-low controls are sampled only at the rising edge (except `outn`/`osel`, combinational).

## Structure
- Package `gp_regbank_pkg`: write-action enum (`WR_NONE`, `WR_LOAD`, `WR_INC`, `WR_DEC`) and the priority-decode function.
- Sub-module `gp_reg_cell`: one `WIDTH`-bit register with action input, next-value logic and wrap detect; instantiated `COUNT` times via generate, action gated by `wsel` decode.
- Top level holds bus mux/tristate, operand latches, `wrap` register, `wz` mux.

## Test plan
- Reset: preload regs, assert `reset` with `outn` = 0 → `bus` = Z, `alu_l` = `alu_r` = 0, `wrap` = 0, all regs read 0 afterwards.
- Load/readback: external drive 0x3A, `loadn` = 0, `wsel` = 2, one edge; release; `outn` = 0, `osel` = 2 → `bus` = 0x3A; `osel` = 1 → 0x00.
- Wrap: load 0xFF into r1, `incn` = 0 one edge → r1 = 0x00, `wz` = 1, `wrap` = 1 one cycle then 0; `decn` = 0 → r1 = 0xFF, `wrap` = 1.
- Priority: r0 = 0x10, `loadn` = `incn` = 0 with bus 0x55 → r0 = 0x55; `incn` = `decn` = 0 → r0 stays 0x55, `wrap` = 0.
- Latch ordering: r3 = 0x07, `loadn` = 0 (`wsel` = 3, bus 0x99) and `loutn` = `routn` = 0 (`lsel` = `rsel` = 3) same edge → `alu_l` = `alu_r` = 0x07, r3 = 0x99; next capture → 0x99.
- Bus move: r0 = 0x42, `outn` = 0, `osel` = 0, `loadn` = 0, `wsel` = 1 → r1 = 0x42 after one edge; `WIDTH` = 16, `COUNT` = 8 rerun of load/wrap passes.
